// File: rtl/lcd_bus_if.sv
// lcd_bus_if: HD44780-style character-LCD bus (rs, rw, en, data).
// master drives the bus (encryptor side); slave receives it (lcd_bus_receiver).
interface lcd_bus_if;
    logic       disp_rs;
    logic       disp_rw;
    logic       disp_en;
    logic [7:0] disp_data;
    modport master (output disp_rs, disp_rw, disp_en, disp_data);
    modport slave  (input  disp_rs, disp_rw, disp_en, disp_data);
endinterface

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: decodes enable-strobed LCD bus writes into a 2x16 frame buffer, cursor and display state.
// Ports: clk, rst (async, active-low), bus (lcd_bus_if.slave), frame (char 0 in [255:248]),
// cursor, char_wr/cmd_wr/frame_done pulses, disp_on, incr_mode, busy, sticky err.
// Optional LCD_RX_SYNC_EN: 2-flop input synchronizer, latency 3 instead of 1.
module lcd_bus_receiver #(
    parameter int         BUSY_CYCLES = 16,
    parameter logic [7:0] CLR_CHAR    = 8'h20
) (
    input  logic           clk,
    input  logic           rst,
    lcd_bus_if.slave       bus,
    output logic [255:0]   frame,
    output logic [4:0]     cursor,
    output logic           char_wr,
    output logic           cmd_wr,
    output logic           frame_done,
    output logic           disp_on,
    output logic           incr_mode,
    output logic           busy,
    output logic           err
);
    localparam int CW = $clog2(BUSY_CYCLES + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [10:0]   bus_in;
    logic [10:0]   smp;
    logic          en_prev;
    logic          fall;
    logic          rs_s;
    logic          rw_s;
    logic [7:0]    d;
`ifdef LCD_RX_SYNC_EN
    logic [10:0] sync1;
    logic [10:0] sync2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.disp_en, bus.disp_rs, bus.disp_rw, bus.disp_data};
            sync2 <= sync1;
        end
    end
    assign bus_in = sync2;
`else
    assign bus_in = {bus.disp_en, bus.disp_rs, bus.disp_rw, bus.disp_data};
`endif
    // smp is the "current" stage: en, rs, rw and data all come from the same sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp     <= '0;
            en_prev <= 1'b0;
        end else begin
            smp     <= bus_in;
            en_prev <= smp[10];
        end
    end
    assign fall = en_prev & ~smp[10];
    assign rs_s = smp[9];
    assign rw_s = smp[8];
    assign d    = smp[7:0];
    assign busy = (state == BUSY);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            frame      <= {32{CLR_CHAR}};
            cursor     <= '0;
            char_wr    <= 1'b0;
            cmd_wr     <= 1'b0;
            frame_done <= 1'b0;
            disp_on    <= 1'b0;
            incr_mode  <= 1'b1;
            err        <= 1'b0;
        end else begin
            char_wr    <= 1'b0;
            cmd_wr     <= 1'b0;
            frame_done <= 1'b0;
            // busy lasts exactly BUSY_CYCLES clocks from entry
            if (state == BUSY) begin
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1))
                    state <= IDLE;
            end
            if (fall && !rw_s) begin
                if (state == BUSY) begin
                    err <= 1'b1;
                end else if (rs_s) begin
                    // char n lives at bits [255-8n -: 8]; ~cursor == 31-cursor
                    frame[{~cursor, 3'b000} +: 8] <= d;
                    char_wr    <= 1'b1;
                    cursor     <= incr_mode ? cursor + 5'd1 : cursor - 5'd1;
                    frame_done <= incr_mode && cursor == 5'd31;
                end else begin
                    cmd_wr <= 1'b1;
                    if (d[7]) begin
                        // DDRAM 0x00-0x0F is line 1, 0x40-0x4F is line 2
                        if (d[5:4] == 2'b00)
                            cursor <= {d[6], d[3:0]};
                        else
                            err <= 1'b1;
                    end else if (d[6:5] == 2'b00) begin
                        if (d[4])
                            cursor <= d[2] ? cursor + 5'd1 : cursor - 5'd1;
                        else if (d[3])
                            disp_on <= d[2];
                        else if (d[2])
                            incr_mode <= d[1];
                        else if (d[1]) begin
                            cursor <= '0;
                            state  <= BUSY;
                            cnt    <= CW'(BUSY_CYCLES);
                        end else if (d[0]) begin
                            frame     <= {32{CLR_CHAR}};
                            cursor    <= '0;
                            incr_mode <= 1'b1;
                            state     <= BUSY;
                            cnt       <= CW'(BUSY_CYCLES);
                        end else
                            err <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
